// File: rtl/mcdf_pkt_formatter_if.sv
// Arbiter-side and bus-side signals of the MCDF packet formatter.
// The formatter takes the slave view; the arbiter/bus model takes the master view.
`timescale 1ns/1ps
interface mcdf_pkt_formatter_if #(
  parameter int DW = 32
);
  logic          a2f_valid_i;
  logic [2:0]    a2f_pkglen_sel_i;
  logic [1:0]    a2f_id_i;
  logic [DW-1:0] a2f_data_i;
  logic          fmt_grant_i;
  logic          f2a_id_req_o;
  logic          f2a_ack_o;
  logic [1:0]    fmt_chid_o;
  logic [5:0]    fmt_length_o;
  logic          fmt_req_o;
  logic [DW-1:0] fmt_data_o;
  logic          fmt_start_o;
  logic          fmt_end_o;

  modport slave (
    input  a2f_valid_i, a2f_pkglen_sel_i, a2f_id_i, a2f_data_i, fmt_grant_i,
    output f2a_id_req_o, f2a_ack_o, fmt_chid_o, fmt_length_o, fmt_req_o,
           fmt_data_o, fmt_start_o, fmt_end_o
  );

  modport master (
    output a2f_valid_i, a2f_pkglen_sel_i, a2f_id_i, a2f_data_i, fmt_grant_i,
    input  f2a_id_req_o, f2a_ack_o, fmt_chid_o, fmt_length_o, fmt_req_o,
           fmt_data_o, fmt_start_o, fmt_end_o
  );
endinterface

// File: rtl/mcdf_pkt_formatter.sv
// Single-packet buffer: collect one packet from the arbiter, request the bus, stream it out framed.
// Output starts two edges after grant is sampled; new words are refused (no ack) until the buffer drains.
`timescale 1ns/1ps
module mcdf_pkt_formatter #(
  parameter int DW     = 32,
  parameter int MAXLEN = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mcdf_pkt_formatter_if.slave   bus,
  output logic [2:0]            current_state,
  output logic [6:0]            fmt_cnt
);
  localparam int AW = $clog2(MAXLEN);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RECV       = 3'd1,
    WAIT_GRANT = 3'd2,
    SEND       = 3'd3
  } state_t;

  state_t        state_q;
  logic [6:0]    cnt_q;
  logic [5:0]    len_q;
  logic [5:0]    len_dec;
  logic [1:0]    chid_q;
  logic          req_q;
  logic          start_q;
  logic          end_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] mem [MAXLEN];
  logic          ack;
  logic [AW-1:0] wr_addr;
  logic          last_recv;
  logic          last_send;

  always_comb begin
    case (bus.a2f_pkglen_sel_i)
      3'd0:    len_dec = 6'd4;
      3'd1:    len_dec = 6'd8;
      3'd2:    len_dec = 6'd16;
      default: len_dec = 6'd32;
    endcase
  end

  assign ack       = bus.a2f_valid_i & ((state_q == IDLE) | (state_q == RECV));
  assign wr_addr   = (state_q == IDLE) ? '0 : cnt_q[AW-1:0];
  assign last_recv = (cnt_q + 7'd1) == {1'b0, len_q};
  assign last_send = cnt_q == ({1'b0, len_q} - 7'd1);

  // Buffer is never reset: a reset only abandons the packet, stale words are overwritten.
  always_ff @(posedge clk_i) begin
    if (ack) begin
      mem[wr_addr] <= bus.a2f_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      chid_q  <= '0;
      req_q   <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      start_q <= 1'b0;
      end_q   <= 1'b0;
      data_q  <= '0;
      case (state_q)
        IDLE: begin
          if (bus.a2f_valid_i) begin
            chid_q  <= bus.a2f_id_i;
            len_q   <= len_dec;
            cnt_q   <= 7'd1;
            state_q <= RECV;
          end
        end
        RECV: begin
          if (bus.a2f_valid_i) begin
            cnt_q <= cnt_q + 7'd1;
            if (last_recv) begin
              state_q <= WAIT_GRANT;
              req_q   <= 1'b1;
            end
          end
        end
        WAIT_GRANT: begin
          if (bus.fmt_grant_i) begin
            state_q <= SEND;
            cnt_q   <= '0;
            req_q   <= 1'b0;
          end
        end
        SEND: begin
          data_q  <= mem[cnt_q[AW-1:0]];
          start_q <= (cnt_q == 7'd0);
          end_q   <= last_send;
          cnt_q   <= cnt_q + 7'd1;
          if (last_send) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.f2a_ack_o    = ack;
  assign bus.f2a_id_req_o = (state_q == IDLE);
  assign bus.fmt_chid_o   = chid_q;
  assign bus.fmt_length_o = len_q;
  assign bus.fmt_req_o    = req_q;
  assign bus.fmt_data_o   = data_q;
  assign bus.fmt_start_o  = start_q;
  assign bus.fmt_end_o    = end_q;
  assign current_state    = state_q;
  assign fmt_cnt          = cnt_q;
endmodule

// File: tb/tb_mcdf_pkt_formatter.sv
// Bench for mcdf_pkt_formatter: packet table plus reset-mid-packet sequence, output scoreboard.
`timescale 1ns/1ps
module tb_mcdf_pkt_formatter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] current_state;
  logic [6:0] fmt_cnt;

  mcdf_pkt_formatter_if #(.DW(32)) bus ();

  mcdf_pkt_formatter #(.DW(32), .MAXLEN(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .current_state (current_state),
    .fmt_cnt       (fmt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [2:0] sel;
    int         base;
    int         gap;
    int         exp_len;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   out_words = 0;
  int   pkt_done = 0;
  bit   in_pkt = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every word seen between start and end framing must match the next pushed word.
  always @(negedge clk) begin
    if (!rst && (bus.fmt_start_o || in_pkt)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_word", 64'(bus.fmt_data_o), 64'hDEAD);
      end else begin
        cur = sbq.pop_front();
        chk("out_data", 64'(bus.fmt_data_o), 64'(cur.d));
        chk("out_start", 64'(bus.fmt_start_o), 64'(cur.s));
        chk("out_end", 64'(bus.fmt_end_o), 64'(cur.e));
      end
      out_words++;
      in_pkt = !bus.fmt_end_o;
      if (bus.fmt_end_o) pkt_done++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input vec_t v, input int nwords, output int acks);
    int  k = 0;
    bit  gapped = 1'b0;
    acks = 0;
    chk("id_req_idle", 64'(bus.f2a_id_req_o), 64'd1);
    while (k < nwords) begin
      if (k == v.gap && !gapped) begin
        bus.a2f_valid_i = 1'b0;
        @(negedge clk);
        chk("gap_ack", 64'(bus.f2a_ack_o), 64'd0);
        step();
        gapped = 1'b1;
      end else begin
        bus.a2f_valid_i      = 1'b1;
        bus.a2f_id_i         = (k == 0) ? v.id : (v.id ^ 2'b11);
        bus.a2f_pkglen_sel_i = (k == 0) ? v.sel : 3'(v.sel + 3'd1);
        bus.a2f_data_i       = 32'(v.base + 10 * k);
        @(negedge clk);
        if (bus.f2a_ack_o) acks++;
        sbq.push_back('{d: 32'(v.base + 10 * k), s: (k == 0), e: (k == v.exp_len - 1)});
        step();
        k++;
      end
    end
    bus.a2f_valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int acks;
    int d0;
    int o0;
    int t;
    send_pkt(v, v.exp_len, acks);
    chk("ack_count", 64'(acks), 64'(v.exp_len));
    @(negedge clk);
    chk("req_full", 64'(bus.fmt_req_o), 64'd1);
    chk("chid", 64'(bus.fmt_chid_o), 64'(v.id));
    chk("length", 64'(bus.fmt_length_o), 64'(v.exp_len));
    chk("state_wait", 64'(current_state), 64'd2);
    chk("cnt_full", 64'(fmt_cnt), 64'(v.exp_len));
    chk("id_req_busy", 64'(bus.f2a_id_req_o), 64'd0);
    // Offered word while waiting for grant must be refused.
    step();
    bus.a2f_valid_i = 1'b1;
    bus.a2f_data_i  = 32'd330;
    @(negedge clk);
    chk("wait_ack", 64'(bus.f2a_ack_o), 64'd0);
    step();
    bus.a2f_valid_i = 1'b0;
    chk("state_still_wait", 64'(current_state), 64'd2);
    d0 = pkt_done;
    o0 = out_words;
    bus.fmt_grant_i = 1'b1;
    step();
    @(negedge clk);
    chk("state_send", 64'(current_state), 64'd3);
    chk("req_drop", 64'(bus.fmt_req_o), 64'd0);
    chk("start_early", 64'(bus.fmt_start_o), 64'd0);
    chk("cnt_send0", 64'(fmt_cnt), 64'd0);
    step();
    bus.fmt_grant_i = 1'b0;
    @(negedge clk);
    chk("start_latency", 64'(bus.fmt_start_o), 64'd1);
    t = 0;
    while (pkt_done == d0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("pkt_timeout", 64'(pkt_done != d0), 64'd1);
    #1;
    chk("id_req_after", 64'(bus.f2a_id_req_o), 64'd1);
    chk("state_idle", 64'(current_state), 64'd0);
    chk("data_idle", 64'(bus.fmt_data_o), 64'd0);
    chk("end_idle", 64'(bus.fmt_end_o), 64'd0);
    chk("words_out", 64'(out_words - o0), 64'(v.exp_len));
    chk("sb_drained", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t vr;
    int   acks;
    int   o0;
    vecs[0] = '{id: 2'd0, sel: 3'd3, base: 10, gap: 5,  exp_len: 32};
    vecs[1] = '{id: 2'd1, sel: 3'd2, base: 11, gap: -1, exp_len: 16};
    vecs[2] = '{id: 2'd2, sel: 3'd1, base: 12, gap: -1, exp_len: 8};
    vecs[3] = '{id: 2'd3, sel: 3'd0, base: 13, gap: 2,  exp_len: 4};
    vecs[4] = '{id: 2'd1, sel: 3'd7, base: 14, gap: -1, exp_len: 32};

    bus.a2f_valid_i      = 1'b0;
    bus.a2f_pkglen_sel_i = 3'd0;
    bus.a2f_id_i         = 2'd0;
    bus.a2f_data_i       = 32'd0;
    bus.fmt_grant_i      = 1'b0;
    #12;
    chk("rst_state", 64'(current_state), 64'd0);
    chk("rst_cnt", 64'(fmt_cnt), 64'd0);
    chk("rst_req", 64'(bus.fmt_req_o), 64'd0);
    chk("rst_chid", 64'(bus.fmt_chid_o), 64'd0);
    chk("rst_len", 64'(bus.fmt_length_o), 64'd0);
    chk("rst_data", 64'(bus.fmt_data_o), 64'd0);
    chk("rst_start", 64'(bus.fmt_start_o), 64'd0);
    chk("rst_id_req", 64'(bus.f2a_id_req_o), 64'd1);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      step();
    end

    // Reset in the middle of receiving: partial packet is dropped.
    vr = '{id: 2'd1, sel: 3'd1, base: 20, gap: -1, exp_len: 8};
    send_pkt(vr, 3, acks);
    chk("partial_acks", 64'(acks), 64'd3);
    chk("partial_state", 64'(current_state), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_state", 64'(current_state), 64'd0);
    chk("midrst_cnt", 64'(fmt_cnt), 64'd0);
    chk("midrst_req", 64'(bus.fmt_req_o), 64'd0);
    chk("midrst_id_req", 64'(bus.f2a_id_req_o), 64'd1);
    sbq.delete();
    o0 = out_words;
    step();
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_out", 64'(out_words), 64'(o0));
    chk("midrst_req_low", 64'(bus.fmt_req_o), 64'd0);
    run_vec(vecs[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
